// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and widths for the Booth MAC sequencer
package booth_pkg;

    localparam int OP_W            = 16;
    localparam int PROD_W          = 32;
    localparam int MUL_BUSY_CYCLES = 9;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/booth_mac_ctrl_if.sv
// rtl/booth_mac_ctrl_if.sv - operand stream, multiplier and result signals of the MAC sequencer
interface booth_mac_ctrl_if
    import booth_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
);

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              in_last;

    logic              mul_start;
    logic [OP_W-1:0]   mul_x;
    logic [OP_W-1:0]   mul_y;
    logic              mul_busy;
    logic [PROD_W-1:0] mul_z;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_last, mul_busy, mul_z, out_ready,
        output in_ready, mul_start, mul_x, mul_y, out_valid, out_acc, out_cnt, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_last, mul_busy, mul_z, out_ready,
        input  in_ready, mul_start, mul_x, mul_y, out_valid, out_acc, out_cnt, out_ovf
    );

endinterface

// File: rtl/booth_mac_ctrl_mac_acc.sv
// rtl/booth_mac_ctrl_mac_acc.sv - wrapping signed accumulator with term counter and sticky overflow
module mac_acc
    import booth_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc,
    output logic [CNT_W-1:0]  cnt,
    output logic              ovf
);

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             ovf_now;

    assign prod_ext = ACC_W'($signed(prod));
    assign sum      = acc + prod_ext;
    // Same-sign operands whose sum flips sign
    assign ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
            ovf <= ovf | ovf_now;
        end
    end

endmodule

// File: rtl/booth_mac_ctrl.sv
// rtl/booth_mac_ctrl.sv - issues operand pairs to the Booth multiplier and accumulates a dot product
module booth_mac_ctrl
    import booth_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    booth_mac_ctrl_if.slave     bus
);

    state_t           state;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             op_last;
    logic             in_ready_q;
    logic             mul_start_q;
    logic             out_valid_q;
    logic             acc_en;
    logic             acc_clr;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    assign acc_en  = (state == WAIT) && !bus.mul_busy;
    assign acc_clr = (state == OUT) && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_last     <= 1'b0;
            in_ready_q  <= 1'b0;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_a        <= bus.in_a;
                        op_b        <= bus.in_b;
                        op_last     <= bus.in_last;
                        in_ready_q  <= 1'b0;
                        mul_start_q <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        in_ready_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    mul_start_q <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    // Product is valid the first cycle busy is low again
                    if (!bus.mul_busy) begin
                        out_valid_q <= op_last;
                        in_ready_q  <= !op_last;
                        state       <= op_last ? OUT : IDLE;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mac_acc #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .en   (acc_en),
        .clr  (acc_clr),
        .prod (bus.mul_z),
        .acc  (acc_q),
        .cnt  (cnt_q),
        .ovf  (ovf_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_x     = op_a;
    assign bus.mul_y     = op_b;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// tb/tb_booth_mac_ctrl.sv - self-checking bench for booth_mac_ctrl with a behavioural Booth multiplier
module tb_booth_mac_ctrl;
    import booth_pkg::*;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic               last;
        logic [39:0]        acc;
        logic [15:0]        cnt;
        logic               ovf;
    } vec_t;

    typedef struct {
        logic [39:0] acc;
        logic [15:0] cnt;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_mac_ctrl_if #(.ACC_W(40), .CNT_W(16)) bus ();

    booth_mac_ctrl #(.ACC_W(40), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    res_t exp_q[$];
    vec_t tbl[7];

    logic [39:0] m_acc;
    int          m_cnt;
    logic        m_ovf;

    int          accepts = 0;
    int          starts = 0;
    int          dbl_start = 0;
    int          stab_err = 0;
    logic        prev_start = 1'b0;
    logic [15:0] sx = '0;
    logic [15:0] sy = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: busy for MUL_BUSY_CYCLES after start, product from current operands
    int bcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt         <= 0;
            bus.mul_busy <= 1'b0;
            bus.mul_z    <= '0;
        end else if (bus.mul_start) begin
            bcnt         <= MUL_BUSY_CYCLES;
            bus.mul_busy <= 1'b1;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else if (bcnt == 1) begin
            bcnt         <= 0;
            bus.mul_busy <= 1'b0;
            bus.mul_z    <= $signed({{16{bus.mul_x[15]}}, bus.mul_x}) * $signed({{16{bus.mul_y[15]}}, bus.mul_y});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) accepts <= accepts + 1;
            if (bus.mul_start) begin
                starts <= starts + 1;
                if (prev_start) dbl_start <= dbl_start + 1;
                sx <= bus.mul_x;
                sy <= bus.mul_y;
            end else if (bus.mul_busy && (bus.mul_x !== sx || bus.mul_y !== sy)) begin
                stab_err <= stab_err + 1;
            end
            prev_start <= bus.mul_start;
        end else begin
            prev_start <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_add(input logic signed [15:0] a, input logic signed [15:0] b);
        longint p;
        longint s;
        p = longint'(a) * longint'(b);
        s = longint'($signed(m_acc)) + p;
        m_acc = 40'(s);
        if (s > 64'sd549755813887 || s < -64'sd549755813888) m_ovf = 1'b1;
        m_cnt++;
    endtask

    task automatic push_exp(input logic [39:0] acc, input logic [15:0] cnt, input logic ovf);
        res_t r;
        r.acc = acc;
        r.cnt = cnt;
        r.ovf = ovf;
        exp_q.push_back(r);
        model_reset();
    endtask

    task automatic push_model();
        push_exp(m_acc, 16'(m_cnt), m_ovf);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic drive_pair(input logic signed [15:0] a, input logic signed [15:0] b, input logic last);
        int t;
        t = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'd1, 64'd0);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            last_acc_cyc = cyc;
            model_add(a, b);
        end
    endtask

    task automatic collect(input bit chk_lat);
        int   t;
        res_t r;
        t = 0;
        while (!bus.out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid) begin
            chk("result_timeout", 64'd1, 64'd0);
        end else if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
        end else begin
            if (chk_lat) chk("latency", 64'(cyc - last_acc_cyc), 64'd11);
            r = exp_q.pop_front();
            chk("out_acc", 64'(bus.out_acc), 64'(r.acc));
            chk("out_cnt", 64'(bus.out_cnt), 64'(r.cnt));
            chk("out_ovf", 64'(bus.out_ovf), 64'(r.ovf));
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("idle_after_result", 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        logic [39:0] snap_acc;
        logic [15:0] snap_cnt;
        logic        snap_ovf;
        int          hold_err;
        int          t;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();

        tbl[0] = '{16'sd3,      16'sd4,      1'b0, 40'd0,          16'd0, 1'b0};
        tbl[1] = '{-16'sd5,     16'sd6,      1'b0, 40'd0,          16'd0, 1'b0};
        tbl[2] = '{16'sh8000,   16'sh8000,   1'b1, 40'd1073741806, 16'd3, 1'b0};
        tbl[3] = '{-16'sd1,     16'sd1,      1'b1, 40'hFF_FFFF_FFFF, 16'd1, 1'b0};
        tbl[4] = '{16'sd32767,  16'sh8000,   1'b1, 40'hFF_C000_8000, 16'd1, 1'b0};
        tbl[5] = '{16'sd100,    -16'sd200,   1'b0, 40'd0,          16'd0, 1'b0};
        tbl[6] = '{-16'sd300,   -16'sd400,   1'b1, 40'd100000,     16'd2, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mul_start", 64'(bus.mul_start), 64'd0);
        chk("rst_outputs",   {bus.out_acc, bus.out_cnt, bus.out_ovf, bus.mul_x[6:0]}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            drive_pair(tbl[i].a, tbl[i].b, tbl[i].last);
            if (tbl[i].last) begin
                push_exp(tbl[i].acc, tbl[i].cnt, tbl[i].ovf);
                collect(1);
            end
        end

        for (int v = 0; v < 6; v++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++)
                drive_pair(16'($urandom), 16'($urandom), j == len - 1);
            push_model();
            collect(1);
        end

        for (int i = 0; i < 512; i++)
            drive_pair(16'sh8000, 16'sh8000, i == 511);
        push_exp(40'h80_0000_0000, 16'd512, 1'b1);
        collect(1);

        // Result held back: no accept, stable outputs, then a fresh vector from zero
        drive_pair(16'sd10, 16'sd10, 1'b1);
        push_exp(40'd100, 16'd1, 1'b0);
        t = 0;
        while (!bus.out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("hold_reach_out", 64'(bus.out_valid), 64'd1);
        snap_acc = bus.out_acc;
        snap_cnt = bus.out_cnt;
        snap_ovf = bus.out_ovf;
        bus.in_a     = 16'sd2;
        bus.in_b     = 16'sd3;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        hold_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_acc !== snap_acc ||
                bus.out_cnt !== snap_cnt || bus.out_ovf !== snap_ovf)
                hold_err++;
        end
        chk("hold_stable", 64'(hold_err), 64'd0);
        collect(0);
        drive_pair(16'sd2, 16'sd3, 1'b1);
        push_model();
        collect(1);

        // Reset during WAIT of the second pair
        drive_pair(16'sd3, 16'sd3, 1'b0);
        drive_pair(16'sd5, 16'sd5, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(bus.mul_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", {bus.in_ready, bus.out_valid, bus.mul_start}, 64'd0);
        chk("midrst_data", {bus.out_acc, bus.out_cnt, bus.out_ovf, bus.mul_x[6:0]}, 64'd0);
        chk("midrst_mul_y", 64'(bus.mul_y), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_pair(16'sd7, 16'sd7, 1'b1);
        push_model();
        collect(1);

        repeat (3) @(negedge clk);
        chk("start_count",  64'(starts), 64'(accepts));
        chk("double_start", 64'(dbl_start), 64'd0);
        chk("xy_stable",    64'(stab_err), 64'd0);
        chk("queue_empty",  64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
